miniproject_axil_slave: RTL

AXI4-Lite responder (slave) register file for the miniproject IP. It is the S00_AXI endpoint that the master VIP's single-beat AXI4LITE_WRITE_BURST / AXI4LITE_READ_BURST transactions terminate on. It provides NUM_REGS 32-bit read/write registers with byte strobes, independent write and read channel FSMs, and OKAY/SLVERR responses. Register contents are exported to the user logic.

---
 rtl/miniproject_axil_pkg.sv | 12 +
 rtl/miniproject_axil_slave_if.sv | 32 +++
 rtl/miniproject_regfile.sv | 33 +++
 rtl/miniproject_axil_slave.sv | 81 ++++++++
 4 files changed

// File: rtl/miniproject_axil_pkg.sv
// miniproject_axil_pkg: response codes, FSM state types and byte-lane merge for the AXI4-Lite register slave
package miniproject_axil_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/miniproject_axil_slave_if.sv
// miniproject_axil_slave_if: AXI4-Lite bus bundle with master and slave views
interface miniproject_axil_slave_if #(parameter int C_S_AXI_ADDR_WIDTH = 4);
  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [2:0] S_AXI_AWPROT;
  logic S_AXI_AWVALID;
  logic S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0] S_AXI_WSTRB;
  logic S_AXI_WVALID;
  logic S_AXI_WREADY;
  logic [1:0] S_AXI_BRESP;
  logic S_AXI_BVALID;
  logic S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [2:0] S_AXI_ARPROT;
  logic S_AXI_ARVALID;
  logic S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0] S_AXI_RRESP;
  logic S_AXI_RVALID;
  logic S_AXI_RREADY;
  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
           S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
           S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/miniproject_regfile.sv
// miniproject_regfile: strobed register storage with combinational read port and per-register write pulses
module miniproject_regfile import miniproject_axil_pkg::*; #(
  parameter int NUM_REGS = 4,
  parameter int IDX_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0] wdata,
  input  logic [3:0] wstrb,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0] rdata,
  output logic [32*NUM_REGS-1:0] regs_out,
  output logic [NUM_REGS-1:0] wr_pulse
);
  logic [NUM_REGS-1:0][31:0] mem;
  // out-of-range indices match no register, so they neither write nor pulse and read as 0
  always_ff @(posedge clk)
    if (rst) begin
      mem <= '0;
      wr_pulse <= '0;
    end else
      for (int k = 0; k < NUM_REGS; k++) begin
        wr_pulse[k] <= we && widx == IDX_W'(k);
        if (we && widx == IDX_W'(k)) mem[k] <= byte_merge(mem[k], wdata, wstrb);
      end
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_REGS; k++) rdata = ridx == IDX_W'(k) ? mem[k] : rdata;
  end
  assign regs_out = mem;
endmodule

// File: rtl/miniproject_axil_slave.sv
// miniproject_axil_slave: AXI4-Lite register file slave with independent write/read FSMs and OKAY/SLVERR decode
module miniproject_axil_slave import miniproject_axil_pkg::*; #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS = 4
) (
  input  logic ACLK,
  input  logic ARESET,
  miniproject_axil_slave_if.slave s_axi,
  output logic [32*NUM_REGS-1:0] regs_out,
  output logic [NUM_REGS-1:0] wr_pulse
);
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  w_state_t w_q, w_d;
  r_state_t r_q, r_d;
  logic [IW-1:0] awidx_q, widx, ridx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [3:0] wstrb_q, cstrb;
  logic [31:0] cdata, rdata_q, rf_rdata;
  logic [1:0] bresp_q, rresp_q;
  logic aw_hs, w_hs, ar_hs, commit;
  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
  always_ff @(posedge ACLK) begin
    w_q <= ARESET ? W_IDLE : w_d;
    r_q <= ARESET ? R_IDLE : r_d;
  end
  always_comb begin
    s_axi.S_AXI_AWREADY = w_q == W_IDLE || w_q == W_WAIT_ADDR;
    s_axi.S_AXI_WREADY = w_q == W_IDLE || w_q == W_WAIT_DATA;
    s_axi.S_AXI_BVALID = w_q == W_RESP;
    s_axi.S_AXI_BRESP = bresp_q;
    s_axi.S_AXI_ARREADY = r_q == R_IDLE;
    s_axi.S_AXI_RVALID = r_q == R_DATA;
    s_axi.S_AXI_RDATA = rdata_q;
    s_axi.S_AXI_RRESP = rresp_q;
    aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    w_hs = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
    ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    commit = w_q == W_IDLE ? aw_hs && w_hs : w_q == W_WAIT_DATA ? w_hs : w_q == W_WAIT_ADDR ? aw_hs : 1'b0;
    w_d = commit ? W_RESP :
          w_q == W_IDLE && aw_hs ? W_WAIT_DATA :
          w_q == W_IDLE && w_hs ? W_WAIT_ADDR :
          w_q == W_RESP && s_axi.S_AXI_BREADY ? W_IDLE : w_q;
    r_d = ar_hs ? R_DATA : r_q == R_DATA && s_axi.S_AXI_RREADY ? R_IDLE : r_q;
    // the half that arrived first comes from the latch, the other half straight off the bus
    widx = w_q == W_WAIT_DATA ? awidx_q : s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    cdata = w_q == W_WAIT_ADDR ? wdata_q : s_axi.S_AXI_WDATA;
    cstrb = w_q == W_WAIT_ADDR ? wstrb_q : s_axi.S_AXI_WSTRB;
    ridx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  end
  always_ff @(posedge ACLK)
    if (ARESET) begin
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
    end else begin
      if (aw_hs) awidx_q <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end
      if (commit) bresp_q <= int'(widx) < NUM_REGS ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs) begin
        rdata_q <= rf_rdata;
        rresp_q <= int'(ridx) < NUM_REGS ? RESP_OKAY : RESP_SLVERR;
      end
    end
  miniproject_regfile #(.NUM_REGS(NUM_REGS), .IDX_W(IW)) u_regfile (
    .clk(ACLK),
    .rst(ARESET),
    .we(commit),
    .widx(widx),
    .wdata(cdata),
    .wstrb(cstrb),
    .ridx(ridx),
    .rdata(rf_rdata),
    .regs_out(regs_out),
    .wr_pulse(wr_pulse)
  );
endmodule
